cache_tag_lookup_ctrl: RTL and testbench
========================================

// Module: cache_tag_lookup_ctrl
// PURPOSE
// - Lookup/refill controller driving the 2-way cache tag RAM from the request side.
// - Accepts CPU requests, reads the index, compares both ways and reports hit/way.
// - On a miss it picks a victim, issues a line-miss request, writes the new tag after refill, then replays the lookup.
// - Sequences the post-reset tag clear sweep and maintains the per-set LRU bit.
// PARAMETERS
// - ADDR_WIDTH   7   tag RAM index bits (sets = 1<<ADDR_WIDTH)
// - OFFSET_WIDTH 5   line offset bits; tag = addr[31:ADDR_WIDTH+OFFSET_WIDTH], fixed 20 b
// PORTS
// - clk           in   1   clock
// - rst           in   1   reset, synchronous, active-high
// - req_valid     in   1   lookup request
// - req_ready     out  1   high only in IDLE
// - req_addr      in   32  physical address
// - resp_valid    out  1   one-cycle pulse: lookup hit result
// - resp_way      out  1   hitting way
// - miss_valid    out  1   line fetch request, held until miss_ready
// - miss_ready    in   1   fetch accepted
// - miss_addr     out  32  line-aligned address (offset bits zero)
// - miss_way      out  1   victim way
// - refill_done   in   1   line data written; sampled only in MISS_WAIT
// - tr_raddr, tr_waddr, tr_bit_raddr  out  ADDR_WIDTH  tag RAM addresses
// - tr_re, tr_we, tr_refill, tr_select  out  1  tag RAM controls (tr_select tied 0)
// - tr_din        out  45  {lru,1'b0,way1{v,tag20},1'b0,way0{v,tag20}}
// - tr_dout       in   45  same format, valid one cycle after read address
// - tr_cache_reset out 1   low = clear sweep active
// - stat_hits, stat_misses  out  32  counters (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state INIT, all outputs 0, sweep counter 0, stat counters 0.
// - INIT: tr_cache_reset=0 for exactly 1<<ADDR_WIDTH cycles after rst deasserts, then 1; -> IDLE.
// - IDLE: req_ready=1; on req_valid capture addr, drive tr_raddr=index, tr_re=1; -> LOOKUP.
// - LOOKUP: tr_dout valid; hitN = vN & (tagN==req tag); both-hit treated as way0.
//   - hit: resp_valid=1, resp_way; tr_we=1, tr_bit_raddr=index, tr_din[44]=~way; -> IDLE. Latency accept->resp = 1 cycle.
//   - miss: capture tr_dout; victim = way0 if !v0, else way1 if !v1, else tr_dout[44]; -> MISS_REQ.
// - MISS_REQ: miss_valid=1 stable until miss_ready sampled high; -> MISS_WAIT.
// - MISS_WAIT: wait refill_done (any number of cycles) -> REFILL_WR.
// - REFILL_WR: tr_refill=1, tr_waddr=index, tr_din = captured line with victim way = {1,tag}, other way unchanged, lru=~victim; -> REPLAY.
// - REPLAY: re-read index (tr_raddr, tr_re=1) -> LOOKUP; guaranteed hit.
// - refill_done outside MISS_WAIT ignored; req_valid outside IDLE not accepted.
// - rst in any state: immediate return to INIT, miss_valid drops same cycle, sweep restarts.
// - Sweep counter wraps at 1<<ADDR_WIDTH; INIT exit on wrap.
// CONFIGURATION
// - CACHE_TAG_STATS_EN defined: stat_hits +1 per LOOKUP hit excluding replays, stat_misses +1 per entry to MISS_REQ; both wrap at 2^32, cleared by rst.
// - Undefined: stat_hits/stat_misses tied 0, no counter logic.
// TESTING
// - rst 1 cycle -> tr_cache_reset low exactly 128 cycles, req_ready 0 throughout, then IDLE.
// - req 0x1234_5680 on empty cache -> miss_valid, miss_addr 0x1234_5680, miss_way 0; refill_done -> tr_refill write, replay, resp_valid way 0.
// - same index, tag 0xABCDE -> victim way1; third tag -> victim = lru (way0), lru written 1.
// - hit on way1 -> resp_valid 1 cycle after accept, tr_we with tr_din[44]=0.
// - miss_ready low 5 cycles -> miss_valid/miss_addr stable; refill_done early ignored.
// - rst during MISS_WAIT -> miss_valid 0, INIT sweep 128 cycles; stats (with CACHE_TAG_STATS_EN) return 0.

Source files
------------

// File: rtl/cache_tag_lookup_ctrl.sv
// cache_tag_lookup_ctrl: request-side lookup/refill controller for a 2-way cache tag RAM.
// Define CACHE_TAG_STATS_EN to build the hit/miss statistics counters (tied to zero otherwise).
module cache_tag_lookup_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned OFFSET_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  output logic                  resp_way,
  output logic                  miss_valid,
  input  logic                  miss_ready,
  output logic [31:0]           miss_addr,
  output logic                  miss_way,
  input  logic                  refill_done,
  output logic [ADDR_WIDTH-1:0] tr_raddr,
  output logic [ADDR_WIDTH-1:0] tr_waddr,
  output logic [ADDR_WIDTH-1:0] tr_bit_raddr,
  output logic                  tr_re,
  output logic                  tr_we,
  output logic                  tr_refill,
  output logic                  tr_select,
  output logic [44:0]           tr_din,
  input  logic [44:0]           tr_dout,
  output logic                  tr_cache_reset,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
);

  localparam int unsigned TAG_W   = 20;
  localparam int unsigned WAY_W   = TAG_W + 1;
  localparam int unsigned LINE_W  = 45;
  localparam int unsigned TAG_LSB = ADDR_WIDTH + OFFSET_WIDTH;
  localparam logic [31:0] OFF_MASK = (32'd1 << OFFSET_WIDTH) - 32'd1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_REFILL_WR,
    S_REPLAY
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [WAY_W-1:0]      way0_q, way0_d;
  logic [WAY_W-1:0]      way1_q, way1_d;
  logic                  victim_q, victim_d;

  logic [TAG_W-1:0]      tag_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  hit0, hit1, lookup_hit, hit_way, victim_c;
  logic [LINE_W-1:0]     refill_line;

  assign tag_q = TAG_W'(addr_q >> TAG_LSB);
  assign idx_q = ADDR_WIDTH'(addr_q >> OFFSET_WIDTH);

  // Way compare on the entry read back in LOOKUP; a double hit resolves to way 0.
  assign hit0       = tr_dout[20] && (tr_dout[19:0] == tag_q);
  assign hit1       = tr_dout[42] && (tr_dout[41:22] == tag_q);
  assign lookup_hit = hit0 || hit1;
  assign hit_way    = !hit0;
  assign victim_c   = !tr_dout[20] ? 1'b0 : (!tr_dout[42] ? 1'b1 : tr_dout[44]);

  assign refill_line = {~victim_q, 1'b0,
                        victim_q ? {1'b1, tag_q} : way1_q,
                        1'b0,
                        victim_q ? way0_q : {1'b1, tag_q}};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      addr_q   <= '0;
      way0_q   <= '0;
      way1_q   <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      way0_q   <= way0_d;
      way1_q   <= way1_d;
      victim_q <= victim_d;
    end
  end

  // Next-state and tag RAM / handshake outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    way0_d         = way0_q;
    way1_d         = way1_q;
    victim_d       = victim_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_way       = 1'b0;
    miss_valid     = 1'b0;
    miss_addr      = '0;
    miss_way       = 1'b0;
    tr_raddr       = '0;
    tr_waddr       = '0;
    tr_bit_raddr   = '0;
    tr_re          = 1'b0;
    tr_we          = 1'b0;
    tr_refill      = 1'b0;
    tr_select      = 1'b0;
    tr_din         = '0;
    tr_cache_reset = 1'b1;

    case (state_q)
      S_INIT: begin
        // The sweep counter also addresses the entry being cleared.
        tr_cache_reset = 1'b0;
        tr_waddr       = cnt_q;
        cnt_d          = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tr_re    = 1'b1;
          tr_raddr = ADDR_WIDTH'(req_addr >> OFFSET_WIDTH);
          addr_d   = req_addr;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          resp_valid   = 1'b1;
          resp_way     = hit_way;
          tr_we        = 1'b1;
          tr_bit_raddr = idx_q;
          tr_din       = {~hit_way, tr_dout[43:0]};
          state_d      = S_IDLE;
        end else begin
          way0_d   = tr_dout[20:0];
          way1_d   = tr_dout[42:22];
          victim_d = victim_c;
          state_d  = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        miss_valid = 1'b1;
        miss_addr  = addr_q & ~OFF_MASK;
        miss_way   = victim_q;
        if (miss_ready) state_d = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (refill_done) state_d = S_REFILL_WR;
      end
      S_REFILL_WR: begin
        tr_refill = 1'b1;
        tr_waddr  = idx_q;
        tr_din    = refill_line;
        state_d   = S_REPLAY;
      end
      S_REPLAY: begin
        tr_re    = 1'b1;
        tr_raddr = idx_q;
        state_d  = S_LOOKUP;
      end
      default: state_d = S_INIT;
    endcase

    // Reset forces every output low in the same cycle, whatever the state.
    if (rst) begin
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_way       = 1'b0;
      miss_valid     = 1'b0;
      miss_addr      = '0;
      miss_way       = 1'b0;
      tr_raddr       = '0;
      tr_waddr       = '0;
      tr_bit_raddr   = '0;
      tr_re          = 1'b0;
      tr_we          = 1'b0;
      tr_refill      = 1'b0;
      tr_din         = '0;
      tr_cache_reset = 1'b0;
    end
  end

`ifdef CACHE_TAG_STATS_EN
  logic        replay_q;
  logic [31:0] stat_hits_q, stat_misses_q;
  logic        hit_evt, miss_evt;

  assign hit_evt  = (state_q == S_LOOKUP) && lookup_hit && !replay_q;
  assign miss_evt = (state_q == S_LOOKUP) && !lookup_hit;

  // replay_q marks a LOOKUP entered from REPLAY so refill replays are not counted as hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_q      <= 1'b0;
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      replay_q <= (state_q == S_REPLAY);
      if (hit_evt)  stat_hits_q   <= stat_hits_q + 32'd1;
      if (miss_evt) stat_misses_q <= stat_misses_q + 32'd1;
    end
  end

  assign stat_hits   = rst ? '0 : stat_hits_q;
  assign stat_misses = rst ? '0 : stat_misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_cache_tag_lookup_ctrl.sv
// Bench for cache_tag_lookup_ctrl: random requests checked by a scoreboard against a per-set cache model.
// Build with CACHE_TAG_STATS_EN defined on both files to check the statistics counters.
`timescale 1ns/1ps
module tb_cache_tag_lookup_ctrl;

  localparam int unsigned AW   = 7;
  localparam int unsigned SETS = 1 << AW;
`ifdef CACHE_TAG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          resp_valid, resp_way;
  logic          miss_valid, miss_way;
  logic          miss_ready;
  logic [31:0]   miss_addr;
  logic          refill_done;
  logic [AW-1:0] tr_raddr, tr_waddr, tr_bit_raddr;
  logic          tr_re, tr_we, tr_refill, tr_select;
  logic [44:0]   tr_din, tr_dout;
  logic          tr_cache_reset;
  logic [31:0]   stat_hits, stat_misses;

  cache_tag_lookup_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_way(resp_way),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr), .miss_way(miss_way),
    .refill_done(refill_done),
    .tr_raddr(tr_raddr), .tr_waddr(tr_waddr), .tr_bit_raddr(tr_bit_raddr),
    .tr_re(tr_re), .tr_we(tr_we), .tr_refill(tr_refill), .tr_select(tr_select),
    .tr_din(tr_din), .tr_dout(tr_dout), .tr_cache_reset(tr_cache_reset),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tag RAM: registered read, full-entry refill write, LRU-bit write, clear during sweep.
  // Contents are scrambled while rst is high so only the sweep can make them clean.
  logic [44:0] ram [SETS];
  always @(posedge clk) begin
    if (tr_re) tr_dout <= ram[tr_raddr];
    if (rst) begin
      for (int i = 0; i < int'(SETS); i++) ram[i] <= 45'({$urandom, $urandom});
    end else begin
      if (!tr_cache_reset) ram[tr_waddr] <= '0;
      if (tr_refill) ram[tr_waddr] <= tr_din;
      if (tr_we) ram[tr_bit_raddr][44] <= tr_din[44];
    end
  end

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: per-set valid/tag for both ways plus the victim pointer.
  logic        m_v   [2][SETS];
  logic [19:0] m_tag [2][SETS];
  logic        m_lru [SETS];
  int unsigned exp_hits, exp_misses;

  typedef struct {
    logic        is_miss;
    logic        way;
    logic [31:0] addr;
    logic        lru;
    logic [6:0]  idx;
    int          cyc;
  } exp_t;
  typedef struct {
    logic [6:0]  idx;
    logic [44:0] din;
  } ref_t;
  exp_t exp_q[$];
  ref_t ref_q[$];

  function automatic void model_clear();
    for (int i = 0; i < int'(SETS); i++) begin
      m_v[0][i] = 1'b0; m_v[1][i] = 1'b0;
      m_tag[0][i] = '0; m_tag[1][i] = '0;
      m_lru[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endfunction

  function automatic void model_predict(input logic [31:0] a, input int c);
    logic [6:0]  idx = a[11:5];
    logic [19:0] t   = a[31:12];
    logic        w;
    exp_t        e;
    ref_t        r;
    if ((m_v[0][idx] && m_tag[0][idx] == t) || (m_v[1][idx] && m_tag[1][idx] == t)) begin
      w = !(m_v[0][idx] && m_tag[0][idx] == t);
      m_lru[idx] = !w;
      e = '{1'b0, w, 32'h0, !w, idx, c};
      exp_q.push_back(e);
      exp_hits++;
    end else begin
      w = !m_v[0][idx] ? 1'b0 : (!m_v[1][idx] ? 1'b1 : m_lru[idx]);
      e = '{1'b1, w, {a[31:5], 5'b0}, 1'b0, idx, -1};
      exp_q.push_back(e);
      m_v[w][idx]   = 1'b1;
      m_tag[w][idx] = t;
      m_lru[idx]    = !w;
      r.idx = idx;
      r.din = {m_lru[idx], 1'b0, m_v[1][idx], m_tag[1][idx], 1'b0, m_v[0][idx], m_tag[0][idx]};
      ref_q.push_back(r);
      e = '{1'b0, w, 32'h0, !w, idx, -1};
      exp_q.push_back(e);
      exp_misses++;
    end
  endfunction

  // Miss-side responder: random fetch acceptance and refill completion pulses.
  int hold_ready = 0;
  bit refill_en  = 1'b1;
  initial begin
    miss_ready  = 1'b0;
    refill_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_ready > 0) begin
        miss_ready = 1'b0;
        hold_ready--;
      end else begin
        miss_ready = ($urandom_range(0, 2) != 0);
      end
      refill_done = refill_en && ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a response, fetch or refill write.
  bit          hs = 1'b0, wait_ok = 1'b0;
  logic        prev_mv = 1'b0, prev_mr = 1'b0, prev_mw = 1'b0;
  logic [31:0] prev_ma = '0;
  initial begin
    exp_t e;
    ref_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs = 1'b0; wait_ok = 1'b0; prev_mv = 1'b0; prev_mr = 1'b0;
      end else begin
        if (prev_mv && !prev_mr)
          check("miss_hold", {miss_valid, miss_way, miss_addr}, {1'b1, prev_mw, prev_ma});
        if (resp_valid) begin
          if (exp_q.size() == 0 || exp_q[0].is_miss) begin
            check("resp_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("resp_way", resp_way, e.way);
            check("lru_write", {tr_we, tr_bit_raddr, tr_din[44]}, {1'b1, e.idx, e.lru});
            if (e.cyc >= 0) check("hit_latency", cyc, e.cyc + 1);
          end
        end
        if (miss_valid && miss_ready) begin
          if (exp_q.size() == 0 || !exp_q[0].is_miss) begin
            check("miss_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("miss_addr_way", {miss_addr, miss_way}, {e.addr, e.way});
          end
          hs = 1'b1; wait_ok = 1'b0;
        end else if (hs && refill_done) begin
          wait_ok = 1'b1;
        end
        if (tr_refill) begin
          check("refill_after_done", wait_ok, 1'b1);
          if (ref_q.size() == 0) begin
            check("refill_unexpected", 1'b1, 1'b0);
          end else begin
            r = ref_q.pop_front();
            check("refill_entry", {tr_waddr, tr_din}, {r.idx, r.din});
          end
          hs = 1'b0; wait_ok = 1'b0;
        end
        prev_mv = miss_valid; prev_mr = miss_ready; prev_mw = miss_way; prev_ma = miss_addr;
      end
    end
  end

  task automatic do_reset();
    int n = 0;
    bit rdy_seen = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    ref_q.delete();
    model_clear();
    #1;
    check("rst_miss_valid", miss_valid, 1'b0);
    check("rst_outputs", {req_ready, resp_valid, tr_re, tr_we, tr_refill, tr_cache_reset, miss_addr},
          {6'b0, 32'h0});
    check("rst_stats", {stat_hits, stat_misses}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    while (tr_cache_reset == 1'b0 && n < 400) begin
      if (req_ready) rdy_seen = 1'b1;
      n++;
      @(posedge clk); #1;
    end
    check("sweep_len", n, 128);
    check("ready_in_sweep", rdy_seen, 1'b0);
    check("ready_after_sweep", req_ready, 1'b1);
    check("stats_after_reset", {stat_hits, stat_misses}, 64'h0);
  endtask

  task automatic do_req(input logic [31:0] a);
    int n = 0;
    while (!req_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 1'b0, 1'b1);
    end else begin
      model_predict(a, cyc);
      req_valid = 1'b1;
      req_addr  = a;
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || ref_q.size() != 0 || !req_ready) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({"drain_", tag}, (exp_q.size() == 0) && (ref_q.size() == 0), 1'b1);
  endtask

  task automatic rand_reqs(input int count);
    for (int k = 0; k < count; k++) begin
      int unsigned ts = $urandom_range(0, 5);
      int unsigned is = $urandom_range(0, 3);
      logic [19:0] t  = 20'(ts * 32'h1F3A7 + 32'd5);
      logic [6:0]  ix = 7'(is * 32'd37);
      do_req({t, ix, 5'($urandom)});
    end
  endtask

  task automatic check_stats(input string tag);
    check({"stat_hits_", tag}, stat_hits, STATS ? 32'(exp_hits) : 32'h0);
    check({"stat_misses_", tag}, stat_misses, STATS ? 32'(exp_misses) : 32'h0);
  endtask

  initial begin
    int n;
    @(posedge clk); #1;
    do_reset();

    // Directed fill of one set: way0, way1, then LRU eviction, then a way1 hit.
    hold_ready = 6;
    do_req(32'h1234_5680);
    do_req({20'hABCDE, 7'h34, 5'h00});
    do_req({20'h55555, 7'h34, 5'h00});
    do_req({20'hABCDE, 7'h34, 5'h11});
    drain("directed");
    check_stats("directed");

    rand_reqs(300);
    drain("random");
    check_stats("random");

    // Reset while a fetch request is being held.
    hold_ready = 1000;
    do_req({20'hFFFFF, 7'h7F, 5'h00});
    n = 0;
    while (!miss_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("miss_before_rst", miss_valid, 1'b1);
    do_reset();
    hold_ready = 0;

    // Reset while waiting for the refill.
    refill_en = 1'b0;
    do_req({20'hFFFFE, 7'h7F, 5'h00});
    n = 0;
    while (!hs && n < 200) begin @(posedge clk); #1; n++; end
    check("handshake_before_rst", hs, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    do_reset();
    refill_en = 1'b1;

    rand_reqs(40);
    drain("post_reset");
    check_stats("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
